// File: rtl/ctrl_pipe.sv
// ============================================================================
// ctrl_pipe
// ----------------------------------------------------------------------------
// Purpose:
//   Carries the decoded control bundle from decode through STAGES downstream
//   pipeline stages (index 0 = E, then M, W, ...). Each stage has its own
//   stall and flush inputs and a valid bit. A stall in stage k holds stages
//   0..k and inserts an all-zero bubble into stage k+1. Bubbles carry no
//   side effects because every control bit in them is zero.
//
// Parameters:
//   W       control bundle width in bits (>=1)
//   STAGES  number of stages after decode (2..8)
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous reset, active-low
//   ctrl_in    in   W         decode-stage control bundle
//   valid_in   in   1         ctrl_in is a real instruction
//   stall      in   STAGES    stall[k]=1: stage k (and all upstream) holds
//   flush      in   STAGES    flush[k]=1: stage k loads a bubble
//   ctrl_out   out  STAGES*W  stage k bundle at [k*W +: W]
//   valid_out  out  STAGES    valid bit per stage
//   inflight   out  4         popcount of valid_out (combinational)
//   stall_up   out  1         hold for decode/fetch (= hold[0])
//
// Optional feature (macro CTRL_PIPE_PERF_EN):
//   bubble_cnt out 32         bubbles inserted by stall back-propagation
//   flush_cnt  out 32         flush bits seen, summed per cycle
//   Both wrap modulo 2^32 and clear on reset.
// ============================================================================
module ctrl_pipe #(
    parameter int W      = 16,
    parameter int STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          ctrl_in,
    input  logic                  valid_in,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   ctrl_out,
    output logic [STAGES-1:0]     valid_out,
    output logic [3:0]            inflight,
    output logic                  stall_up
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    // Set-bit count; 4 bits covers STAGES up to 8.
    function automatic logic [3:0] popcount(input logic [STAGES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < STAGES; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    logic [STAGES-1:0][W-1:0] ctrl_q, ctrl_d;
    logic [STAGES-1:0]        vld_q, vld_d;
    logic [STAGES-1:0]        hold;

    // hold[k] is the OR of stall[k..STAGES-1]: a downstream stall freezes
    // everything behind it.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc | stall[k];
            hold[k] = acc;
        end
    end

    // Next-state per stage: flush > hold > bubble > advance.
    always_comb begin
        ctrl_d = ctrl_q;
        vld_d  = vld_q;

        // Stage 0 (E) captures from decode; a non-valid input is masked to
        // zero so it behaves exactly like a bubble.
        if (flush[0]) begin
            ctrl_d[0] = '0;
            vld_d[0]  = 1'b0;
        end else if (hold[0]) begin
            ctrl_d[0] = ctrl_q[0];
            vld_d[0]  = vld_q[0];
        end else begin
            ctrl_d[0] = ctrl_in & {W{valid_in}};
            vld_d[0]  = valid_in;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (flush[k]) begin
                ctrl_d[k] = '0;
                vld_d[k]  = 1'b0;
            end else if (hold[k]) begin
                ctrl_d[k] = ctrl_q[k];
                vld_d[k]  = vld_q[k];
            end else if (hold[k-1]) begin
                // Upstream frozen but this stage free: emit a bubble so the
                // held instruction is not duplicated downstream.
                ctrl_d[k] = '0;
                vld_d[k]  = 1'b0;
            end else begin
                ctrl_d[k] = ctrl_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            vld_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            vld_q  <= vld_d;
        end
    end

    assign ctrl_out  = ctrl_q;
    assign valid_out = vld_q;
    assign inflight  = popcount(vld_q);
    assign stall_up  = hold[0];

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [STAGES-1:0] bubble_now;

    // A stage counts as a bubble only when the advance-blocked rule is the
    // one that actually fires (not flushed, not itself held).
    always_comb begin
        bubble_now = '0;
        for (int k = 1; k < STAGES; k++) begin
            bubble_now[k] = !flush[k] && !hold[k] && hold[k-1];
        end
        bubble_cnt_d = bubble_cnt_q + {28'd0, popcount(bubble_now)};
        flush_cnt_d  = flush_cnt_q + {28'd0, popcount(flush)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// ============================================================================
// tb_ctrl_pipe
// ----------------------------------------------------------------------------
// Directed bench for ctrl_pipe. Main instance: W=8, STAGES=3. A second
// instance with STAGES=8 shares ctrl_in/valid_in/rst and never stalls.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ============================================================================
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ctrl_in;
    logic        valid_in;
    logic [2:0]  stall, flush;
    logic [23:0] ctrl_out;
    logic [2:0]  valid_out;
    logic [3:0]  inflight;
    logic        stall_up;

    logic [7:0]  stall8, flush8;
    logic [63:0] ctrl_out8;
    logic [7:0]  valid_out8;
    logic [3:0]  inflight8;
    logic        stall_up8;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt, flush_cnt, bubble_cnt8, flush_cnt8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.W(8), .STAGES(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_in   (ctrl_in),
        .valid_in  (valid_in),
        .stall     (stall),
        .flush     (flush),
        .ctrl_out  (ctrl_out),
        .valid_out (valid_out),
        .inflight  (inflight),
        .stall_up  (stall_up)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    ctrl_pipe #(.W(8), .STAGES(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .ctrl_in   (ctrl_in),
        .valid_in  (valid_in),
        .stall     (stall8),
        .flush     (flush8),
        .ctrl_out  (ctrl_out8),
        .valid_out (valid_out8),
        .inflight  (inflight8),
        .stall_up  (stall_up8)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .bubble_cnt(bubble_cnt8),
        .flush_cnt (flush_cnt8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        ctrl_in  = 8'h00;
        valid_in = 1'b0;
        stall    = 3'b000;
        flush    = 3'b000;
        stall8   = 8'h00;
        flush8   = 8'h00;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_ctrl",     {40'd0, ctrl_out}, 64'h0);
        check("rst_valid",    {61'd0, valid_out}, 64'h0);
        check("rst_inflight", {60'd0, inflight}, 64'h0);
        check("rst_stall_up", {63'd0, stall_up}, 64'h0);
        step();
        @(negedge clk);
        rst = 1'b1;

        // Non-valid input is masked to zero
        ctrl_in  = 8'hFF;
        valid_in = 1'b0;
        step();
        check("mask_ctrl",  {40'd0, ctrl_out}, 64'h0);
        check("mask_valid", {61'd0, valid_out}, 64'h0);

        // Free-running stream 11,22,33
        valid_in = 1'b1;
        ctrl_in  = 8'h11; step();
        ctrl_in  = 8'h22; step();
        ctrl_in  = 8'h33; step();
        check("stream_ctrl",     {40'd0, ctrl_out}, {40'd0, 24'h112233});
        check("stream_valid",    {61'd0, valid_out}, 64'd7);
        check("stream_inflight", {60'd0, inflight}, 64'd3);

        // Stall in stage 1 for one cycle
        ctrl_in = 8'h44;
        stall   = 3'b010;
        #1;
        check("stall_up_hi", {63'd0, stall_up}, 64'd1);
        step();
        check("stall_ctrl",  {40'd0, ctrl_out}, {40'd0, 24'h002233});
        check("stall_valid", {61'd0, valid_out}, 64'd3);
        stall = 3'b000;
        #1;
        check("stall_up_lo", {63'd0, stall_up}, 64'd0);
        step();
        check("resume_ctrl",  {40'd0, ctrl_out}, {40'd0, 24'h223344});
        check("resume_valid", {61'd0, valid_out}, 64'd7);
        ctrl_in = 8'h55; step();
        check("resume2_ctrl", {40'd0, ctrl_out}, {40'd0, 24'h334455});

        // Flush and stall stage 0 together
        ctrl_in = 8'h66;
        flush   = 3'b001;
        stall   = 3'b001;
        step();
        check("fs0_ctrl",     {40'd0, ctrl_out}, {40'd0, 24'h440000});
        check("fs0_valid",    {61'd0, valid_out}, 64'd4);
        check("fs0_inflight", {60'd0, inflight}, 64'd1);
        flush   = 3'b000;
        stall   = 3'b000;
        ctrl_in = 8'h77; step();
        check("fs0_next_ctrl",  {40'd0, ctrl_out}, {40'd0, 24'h000077});
        check("fs0_next_valid", {61'd0, valid_out}, 64'd1);

        // Flush stage 0 while stage 1 is stalled: stage 0 becomes a held bubble
        ctrl_in = 8'h88; step();
        check("pre_fs1_ctrl", {40'd0, ctrl_out}, {40'd0, 24'h007788});
        flush   = 3'b001;
        stall   = 3'b010;
        ctrl_in = 8'h99;
        step();
        check("fs1_ctrl",  {40'd0, ctrl_out}, {40'd0, 24'h007700});
        check("fs1_valid", {61'd0, valid_out}, 64'd2);
        flush = 3'b000;
        stall = 3'b000;
        step();
        check("fs1_next_ctrl",  {40'd0, ctrl_out}, {40'd0, 24'h770099});
        check("fs1_next_valid", {61'd0, valid_out}, 64'd5);

        // Asynchronous reset between edges
        ctrl_in = 8'hA5;
        #2 rst = 1'b0;
        #1;
        check("arst_ctrl",     {40'd0, ctrl_out}, 64'h0);
        check("arst_valid",    {61'd0, valid_out}, 64'h0);
        check("arst_inflight", {60'd0, inflight}, 64'h0);
        check("arst_ctrl8",    ctrl_out8, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_ctrl",  {40'd0, ctrl_out}, {40'd0, 24'h0000A5});
        check("post_rst_valid", {61'd0, valid_out}, 64'd1);

`ifdef CTRL_PIPE_PERF_EN
        check("perf_bubble0", {32'd0, bubble_cnt}, 64'd0);
        check("perf_flush0",  {32'd0, flush_cnt}, 64'd0);
        stall = 3'b001;
        for (int i = 0; i < 4; i++) step();
        stall = 3'b000;
        flush = 3'b111;
        step();
        flush = 3'b000;
        check("perf_bubble", {32'd0, bubble_cnt}, 64'd4);
        check("perf_flush",  {32'd0, flush_cnt}, 64'd3);
`endif

        // Eight valid captures fill the deep instance
        for (int i = 0; i < 8; i++) begin
            ctrl_in = 8'h10 + 8'(i);
            step();
        end
        check("deep_inflight", {60'd0, inflight8}, 64'd8);
        check("deep_valid",    {56'd0, valid_out8}, 64'hFF);
        check("deep_ctrl",     ctrl_out8, 64'h1011121314151617);
        check("main_tail",     {40'd0, ctrl_out}, {40'd0, 24'h151617});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000 ns");
        $fatal(1, "timeout");
    end

endmodule
